axi_read_rr_arbiter: RTL and testbench

//  N-master AXI read-channel arbiter for the multi-core cache subsystem; generalises the fixed two-master
//  (m0/m1) read fabric to NUM_MASTERS cache controllers sharing one main-memory read port.

---
 rtl/axi_read_rr_arbiter.sv | 146 ++++++++++++++
 tb/tb_axi_read_rr_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_rr_arbiter.sv
// N-master AXI read-channel arbiter: fair round-robin grant, one full AR+R burst outstanding at a time.
// Optional macro ARB_QOS_EN adds s_ARQOS; the highest QoS requester wins and ties fall back to round-robin.
module axi_read_rr_arbiter #(
  parameter  int NUM_MASTERS = 4,
  parameter  int DATA_WIDTH  = 32,
  parameter  int ADDR_WIDTH  = 32,
  parameter  int ID_WIDTH    = 1,
  localparam int IDX_WIDTH   = ($clog2(NUM_MASTERS) > 0) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [NUM_MASTERS*ID_WIDTH-1:0]   s_ARID,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_ARADDR,
  input  logic [NUM_MASTERS*8-1:0]          s_ARLEN,
  input  logic [NUM_MASTERS-1:0]            s_ARVALID,
`ifdef ARB_QOS_EN
  input  logic [NUM_MASTERS*4-1:0]          s_ARQOS,
`endif
  output logic [NUM_MASTERS-1:0]            s_ARREADY,
  output logic [ID_WIDTH-1:0]               s_RID,
  output logic [DATA_WIDTH-1:0]             s_RDATA,
  output logic [1:0]                        s_RRESP,
  output logic                              s_RLAST,
  output logic [NUM_MASTERS-1:0]            s_RVALID,
  input  logic [NUM_MASTERS-1:0]            s_RREADY,
  output logic [ID_WIDTH+IDX_WIDTH-1:0]     m_ARID,
  output logic [ADDR_WIDTH-1:0]             m_ARADDR,
  output logic [7:0]                        m_ARLEN,
  output logic                              m_ARVALID,
  input  logic                              m_ARREADY,
  input  logic [ID_WIDTH+IDX_WIDTH-1:0]     m_RID,
  input  logic [DATA_WIDTH-1:0]             m_RDATA,
  input  logic [1:0]                        m_RRESP,
  input  logic                              m_RLAST,
  input  logic                              m_RVALID,
  output logic                              m_RREADY
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [IDX_WIDTH-1:0]   r_rr_ptr;
  logic [IDX_WIDTH-1:0]   r_grant;
  logic [IDX_WIDTH-1:0]   w_win;
  logic                   w_found;
  logic [ID_WIDTH-1:0]    r_arid;
  logic [ADDR_WIDTH-1:0]  r_araddr;
  logic [7:0]             r_arlen;
  logic                   w_unused_rid_idx;
`ifdef ARB_QOS_EN
  logic [3:0]             w_best_qos;
`endif

  function automatic int rr_index(input logic [IDX_WIDTH-1:0] base, input int k);
    return (int'(base) + k) % NUM_MASTERS;
  endfunction

  // Scan from the round-robin pointer; the first hit is the winner (or the first of the highest QoS).
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
`ifdef ARB_QOS_EN
    w_best_qos = '0;
`endif
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (s_ARVALID[rr_index(r_rr_ptr, k)]) begin
`ifdef ARB_QOS_EN
        if (!w_found || (s_ARQOS[rr_index(r_rr_ptr, k)*4 +: 4] > w_best_qos)) begin
          w_found    = 1'b1;
          w_win      = IDX_WIDTH'(rr_index(r_rr_ptr, k));
          w_best_qos = s_ARQOS[rr_index(r_rr_ptr, k)*4 +: 4];
        end
`else
        if (!w_found) begin
          w_found = 1'b1;
          w_win   = IDX_WIDTH'(rr_index(r_rr_ptr, k));
        end
`endif
      end
    end
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    s_ARREADY   = '0;
    s_RVALID    = '0;
    m_ARVALID   = 1'b0;
    m_RREADY    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          s_ARREADY[w_win] = 1'b1;
          w_state_nxt      = ST_ADDR;
        end
      end
      ST_ADDR: begin
        m_ARVALID = 1'b1;
        if (m_ARREADY) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        s_RVALID[r_grant] = m_RVALID;
        m_RREADY          = s_RREADY[r_grant];
        if (m_RVALID && s_RREADY[r_grant] && m_RLAST) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_arid   <= '0;
      r_araddr <= '0;
      r_arlen  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_found) begin
        r_grant  <= w_win;
        r_arid   <= s_ARID[w_win*ID_WIDTH +: ID_WIDTH];
        r_araddr <= s_ARADDR[w_win*ADDR_WIDTH +: ADDR_WIDTH];
        r_arlen  <= s_ARLEN[w_win*8 +: 8];
      end
      if (r_state == ST_DATA && w_state_nxt == ST_IDLE) begin
        r_rr_ptr <= IDX_WIDTH'((int'(r_grant) + 1) % NUM_MASTERS);
      end
    end
  end

  assign m_ARID   = {r_grant, r_arid};
  assign m_ARADDR = r_araddr;
  assign m_ARLEN  = r_arlen;

  // R payload is broadcast; only the granted master sees RVALID, so no routing on RID is needed.
  assign s_RID   = m_RID[ID_WIDTH-1:0];
  assign s_RDATA = m_RDATA;
  assign s_RRESP = m_RRESP;
  assign s_RLAST = m_RLAST;

  assign w_unused_rid_idx = ^m_RID[ID_WIDTH+IDX_WIDTH-1:ID_WIDTH];

endmodule

// File: tb/tb_axi_read_rr_arbiter.sv
// Self-checking bench for axi_read_rr_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (round-robin by distance from pointer, QoS max when ARB_QOS_EN is defined).
module tb_axi_read_rr_arbiter;
  localparam int NM = 4;

  logic         ACLK = 1'b0;
  logic         ARESET = 1'b1;
  logic [3:0]   s_ARID;
  logic [127:0] s_ARADDR;
  logic [31:0]  s_ARLEN;
  logic [3:0]   s_ARVALID;
  logic [15:0]  s_ARQOS;
  logic [3:0]   s_ARREADY;
  logic         s_RID;
  logic [31:0]  s_RDATA;
  logic [1:0]   s_RRESP;
  logic         s_RLAST;
  logic [3:0]   s_RVALID;
  logic [3:0]   s_RREADY;
  logic [2:0]   m_ARID;
  logic [31:0]  m_ARADDR;
  logic [7:0]   m_ARLEN;
  logic         m_ARVALID;
  logic         m_ARREADY;
  logic [2:0]   m_RID;
  logic [31:0]  m_RDATA;
  logic [1:0]   m_RRESP;
  logic         m_RLAST;
  logic         m_RVALID;
  logic         m_RREADY;

  axi_read_rr_arbiter #(.NUM_MASTERS(NM), .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(1)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_ARID(s_ARID), .s_ARADDR(s_ARADDR), .s_ARLEN(s_ARLEN), .s_ARVALID(s_ARVALID),
`ifdef ARB_QOS_EN
    .s_ARQOS(s_ARQOS),
`endif
    .s_ARREADY(s_ARREADY), .s_RID(s_RID), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP), .s_RLAST(s_RLAST),
    .s_RVALID(s_RVALID), .s_RREADY(s_RREADY),
    .m_ARID(m_ARID), .m_ARADDR(m_ARADDR), .m_ARLEN(m_ARLEN), .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY),
    .m_RID(m_RID), .m_RDATA(m_RDATA), .m_RRESP(m_RRESP), .m_RLAST(m_RLAST), .m_RVALID(m_RVALID),
    .m_RREADY(m_RREADY)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] beat_data(input logic [31:0] a, input int b);
    return a ^ (32'h9E37_0000 + 32'(b) * 32'h0101);
  endfunction

  // Winner: among valid masters with the maximum QoS, the one at the smallest distance from the pointer.
  function automatic int pick(input logic [3:0] v, input logic [15:0] q, input int ptr);
    int maxq  = -1;
    int best  = -1;
    int bestd = NM;
    for (int i = 0; i < NM; i++)
      if (v[i] && int'(q[i*4 +: 4]) > maxq) maxq = int'(q[i*4 +: 4]);
    for (int i = 0; i < NM; i++) begin
      if (v[i] && int'(q[i*4 +: 4]) == maxq && ((i - ptr + NM) % NM) < bestd) begin
        bestd = (i - ptr + NM) % NM;
        best  = i;
      end
    end
    return best;
  endfunction

  // Transaction-level model state
  bit          mb_busy = 0, mb_addr = 0;
  int          mb_g = 0, mb_ptr = 0, mb_beat = 0;
  logic [31:0] mb_araddr = '0;
  logic [7:0]  mb_len = '0;
  logic        mb_id = 1'b0;
  int          dut_grants[$];
  int          beats_seen[NM];
  bit          last_seen[NM];

  always @(negedge ACLK) begin : chk
    int         w;
    logic [3:0] e_ar, e_rv;
    logic       e_arv, e_rr;
    if (chk_en) begin
      w    = -1;
      e_ar = '0;
      if (!mb_busy) begin
        w = pick(s_ARVALID, s_ARQOS, mb_ptr);
        if (w >= 0) e_ar = 4'(1 << w);
      end
      e_arv = mb_busy && mb_addr;
      e_rv  = (mb_busy && !mb_addr && m_RVALID) ? 4'(1 << mb_g) : 4'b0;
      e_rr  = mb_busy && !mb_addr && s_RREADY[mb_g];
      check("s_ARREADY", s_ARREADY, e_ar);
      check("m_ARVALID", m_ARVALID, e_arv);
      check("m_ARID", m_ARID, {2'(mb_g), mb_id});
      check("m_ARADDR", m_ARADDR, mb_araddr);
      check("m_ARLEN", m_ARLEN, mb_len);
      check("s_RVALID", s_RVALID, e_rv);
      check("m_RREADY", m_RREADY, e_rr);
      check("r_bcast", {s_RID, s_RRESP, s_RLAST, s_RDATA}, {m_RID[0], m_RRESP, m_RLAST, m_RDATA});

      if (!ARESET)
        for (int j = 0; j < NM; j++) if (s_ARREADY[j]) dut_grants.push_back(j);
      for (int j = 0; j < NM; j++) begin
        if (s_RVALID[j] && s_RREADY[j]) begin
          beats_seen[j]++;
          if (s_RLAST) last_seen[j] = 1'b1;
        end
      end

      if (mb_busy && !mb_addr && m_RVALID && s_RREADY[mb_g]) begin
        check("beat_data", s_RDATA, beat_data(mb_araddr, mb_beat));
        check("beat_last", s_RLAST, (mb_beat == int'(mb_len)));
        check("beat_rid", s_RID, mb_id);
      end

      if (ARESET) begin
        mb_busy = 0; mb_addr = 0; mb_g = 0; mb_ptr = 0; mb_beat = 0;
        mb_araddr = '0; mb_len = '0; mb_id = 1'b0;
      end else if (!mb_busy) begin
        if (w >= 0) begin
          mb_busy = 1; mb_addr = 1; mb_g = w;
          mb_araddr = s_ARADDR[w*32 +: 32];
          mb_len    = s_ARLEN[w*8 +: 8];
          mb_id     = s_ARID[w];
        end
      end else if (mb_addr) begin
        if (m_ARREADY) begin mb_addr = 0; mb_beat = 0; end
      end else if (m_RVALID && s_RREADY[mb_g]) begin
        if (m_RLAST) begin mb_busy = 0; mb_ptr = (mb_g + 1) % NM; end
        else mb_beat++;
      end
    end
  end

  // Memory-side slave: one burst at a time, data derived from the burst address and beat number.
  int          ar_prob = 100, r_prob = 100, ar_hold = 0;
  bit          sl_active = 0;
  logic [31:0] sl_addr;
  logic [7:0]  sl_len;
  logic [2:0]  sl_id;
  int          sl_beat = 0;

  initial begin : slave
    logic rst_s, ar_hs, r_hs, last_s;
    logic [31:0] a_s;
    logic [7:0]  l_s;
    logic [2:0]  i_s;
    m_ARREADY = 0; m_RVALID = 0; m_RDATA = 0; m_RLAST = 0; m_RID = 0; m_RRESP = 0;
    forever begin
      @(negedge ACLK);
      rst_s  = ARESET;
      ar_hs  = m_ARVALID & m_ARREADY;
      r_hs   = m_RVALID & m_RREADY;
      last_s = m_RLAST;
      a_s = m_ARADDR; l_s = m_ARLEN; i_s = m_ARID;
      if (m_ARVALID && !m_ARREADY && ar_hold > 0) ar_hold--;
      @(posedge ACLK); #1;
      if (rst_s) begin
        sl_active = 0; m_RVALID = 0; m_RLAST = 0; m_ARREADY = 0;
      end else begin
        if (r_hs) begin
          if (last_s) sl_active = 0;
          else sl_beat++;
        end
        if (ar_hs) begin
          sl_active = 1; sl_addr = a_s; sl_len = l_s; sl_id = i_s; sl_beat = 0;
        end
        if (!sl_active) m_RVALID = 0;
        else if (r_hs || !m_RVALID) m_RVALID = ($urandom_range(99) < r_prob);
        if (sl_active) begin
          m_RDATA = beat_data(sl_addr, sl_beat);
          m_RLAST = (sl_beat == int'(sl_len));
          m_RID   = sl_id;
          m_RRESP = 2'(sl_beat);
        end else m_RLAST = 0;
        m_ARREADY = (ar_hold == 0) && ($urandom_range(99) < ar_prob);
      end
    end
  end

  task automatic cyc();
    @(posedge ACLK); #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [7:0] l, input logic id);
    s_ARADDR[i*32 +: 32] = a;
    s_ARLEN[i*8 +: 8]    = l;
    s_ARID[i]            = id;
  endtask

  task automatic clear_counts();
    for (int j = 0; j < NM; j++) begin beats_seen[j] = 0; last_seen[j] = 0; end
  endtask

  task automatic wait_last(input int m, input int bound);
    int n = 0;
    while (!last_seen[m] && n < bound) begin cyc(); n++; end
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (mb_busy && n < bound) begin cyc(); n++; end
    check(name, m_ARVALID | (s_RVALID != 0) | mb_busy, 1'b0);
  endtask

  task automatic wait_grants(input int cnt, input int bound);
    int n = 0;
    while (dut_grants.size() < cnt && n < bound) begin cyc(); n++; end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int exp2[5] = '{0, 1, 2, 3, 0};
    logic [3:0] acc;
    s_ARVALID = '0; s_ARID = '0; s_ARADDR = '0; s_ARLEN = '0; s_RREADY = 4'hF; s_ARQOS = '0;
    clear_counts();
    ARESET = 1'b1;
    cyc(); chk_en = 1'b1; cyc();
    @(negedge ACLK);
    check("rst_arready", s_ARREADY, 4'b0);
    check("rst_arvalid", m_ARVALID, 1'b0);
    check("rst_arid", m_ARID, 3'b0);
    check("rst_araddr", m_ARADDR, 32'h0);
    cyc(); ARESET = 1'b0;

    // Single requester: master 2, 4-beat burst
    set_req(2, 32'h0002_0040, 8'd3, 1'b1); s_ARVALID = 4'b0100; clear_counts();
    @(negedge ACLK); check("t1_arready", s_ARREADY, 4'b0100);
    cyc(); s_ARVALID = '0;
    @(negedge ACLK);
    check("t1_arvalid", m_ARVALID, 1'b1);
    check("t1_arid", m_ARID, 3'b101);
    check("t1_araddr", m_ARADDR, 32'h0002_0040);
    check("t1_arlen", m_ARLEN, 8'd3);
    wait_last(2, 30);
    check("t1_beats", beats_seen[2], 4);
    check("t1_other_beats", beats_seen[0] + beats_seen[1] + beats_seen[3], 0);
    set_req(0, 32'h0000_1000, 8'd0, 1'b0);
    set_req(1, 32'h0001_1000, 8'd0, 1'b0);
    set_req(3, 32'h0003_1000, 8'd0, 1'b0);
    s_ARVALID = 4'b1011;
    @(negedge ACLK); check("t1_next_rr", s_ARREADY, 4'b1000);
    cyc(); s_ARVALID = '0;
    wait_idle("t1_idle", 40);

    // All four request continuously with single-beat bursts
    ARESET = 1'b1; cyc(); ARESET = 1'b0;
    dut_grants.delete();
    for (int i = 0; i < NM; i++) set_req(i, 32'h0010_0000 + 32'(i) * 32'h100, 8'd0, 1'(i));
    s_ARVALID = 4'hF;
    wait_grants(5, 80);
    s_ARVALID = '0;
    check("t2_ngrants", dut_grants.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("t2_grant%0d", i), (i < dut_grants.size()) ? dut_grants[i] : 99, exp2[i]);
    wait_idle("t2_idle", 40);

    // Memory stalls AR for 5 cycles, then the granted master stalls R for 3 cycles
    ar_hold = 5; cyc();
    set_req(1, 32'h1234_5670, 8'd3, 1'b0); s_ARVALID = 4'b0010; clear_counts();
    @(negedge ACLK); check("t3_arready", s_ARREADY, 4'b0010);
    cyc(); s_ARVALID = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      @(negedge ACLK);
      check("t3_arvalid", m_ARVALID, 1'b1);
      check("t3_araddr", m_ARADDR, 32'h1234_5670);
      check("t3_arid", m_ARID, 3'b010);
      check("t3_no_arready", s_ARREADY, 4'b0);
      cyc();
    end
    s_ARVALID = '0;
    begin
      int n = 0;
      while (beats_seen[1] < 1 && n < 20) begin cyc(); n++; end
    end
    s_RREADY = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK); check("t4_rready_low", m_RREADY, 1'b0);
      cyc();
    end
    check("t4_beats_held", beats_seen[1], 1);
    s_RREADY = 4'hF;
    wait_last(1, 30);
    check("t4_beats", beats_seen[1], 4);
    wait_idle("t4_idle", 40);

    // Reset in the middle of a 4-beat burst
    set_req(2, 32'h0005_5000, 8'd3, 1'b1); s_ARVALID = 4'b0100; clear_counts();
    cyc(); s_ARVALID = '0;
    begin
      int n = 0;
      while (beats_seen[2] < 2 && n < 30) begin cyc(); n++; end
    end
    ARESET = 1'b1; cyc(); ARESET = 1'b0;
    @(negedge ACLK);
    check("t5_arready", s_ARREADY, 4'b0);
    check("t5_rvalid", s_RVALID, 4'b0);
    check("t5_arvalid", m_ARVALID, 1'b0);
    check("t5_rready", m_RREADY, 1'b0);
    check("t5_arid", m_ARID, 3'b0);
    check("t5_araddr", m_ARADDR, 32'h0);
    check("t5_arlen", m_ARLEN, 8'h0);
    cyc();
    set_req(1, 32'h0006_0000, 8'd1, 1'b0);
    set_req(3, 32'h0006_3000, 8'd1, 1'b1);
    s_ARVALID = 4'b1010;
    @(negedge ACLK); check("t5_ptr_reset", s_ARREADY, 4'b0010);
    cyc(); s_ARVALID = '0;
    wait_idle("t5_idle", 40);

`ifdef ARB_QOS_EN
    // QoS: higher QoS wins, equal QoS falls back to round-robin
    set_req(0, 32'h0007_0000, 8'd0, 1'b0);
    set_req(3, 32'h0007_3000, 8'd0, 1'b1);
    s_ARQOS = {4'd7, 4'd0, 4'd0, 4'd1}; s_ARVALID = 4'b1001;
    @(negedge ACLK); check("t6_qos", s_ARREADY, 4'b1000);
    cyc(); s_ARVALID = '0;
    wait_idle("t6_idle", 40);
    s_ARQOS = 16'h5555; dut_grants.delete();
    for (int i = 0; i < NM; i++) set_req(i, 32'h0008_0000 + 32'(i) * 32'h40, 8'd0, 1'b0);
    s_ARVALID = 4'hF;
    wait_grants(4, 60);
    s_ARVALID = '0;
    check("t6_ngrants", dut_grants.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t6_grant%0d", i), (i < dut_grants.size()) ? dut_grants[i] : 99, i);
    wait_idle("t6_idle2", 40);
    s_ARQOS = '0;
`endif

    // Randomized traffic with back-pressure on both sides and rare resets
    ar_prob = 70; r_prob = 70;
    for (int c = 0; c < 3000; c++) begin
      @(negedge ACLK); acc = s_ARREADY;
      cyc();
      ARESET = ($urandom_range(499) == 0);
      for (int i = 0; i < NM; i++) begin
        if (s_ARVALID[i]) begin
          if (acc[i] || $urandom_range(99) < 3) s_ARVALID[i] = 1'b0;
        end else if ($urandom_range(99) < 25) begin
          set_req(i, $urandom, 8'($urandom_range(3)), 1'($urandom_range(1)));
`ifdef ARB_QOS_EN
          s_ARQOS[i*4 +: 4] = 4'($urandom_range(15));
`endif
          s_ARVALID[i] = 1'b1;
        end
        s_RREADY[i] = ($urandom_range(99) < 80);
      end
    end
    ARESET = 1'b0; s_ARVALID = '0; s_RREADY = 4'hF; ar_prob = 100; r_prob = 100;
    wait_idle("final_idle", 100);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
